// File: rtl/core_pkg.sv
// Shared core definitions: IF-stage fetch states and default core parameters.
package core_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_HOLD  = 2'd3
  } ifu_state_t;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues single-latency reads on the
// instruction bus and presents each fetched word (with its PC) to IF/ID.
module ifu
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_stall,
  input  logic            if_flush,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_pc,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_pc,
  output logic            ibus_read,
  output logic [XLEN-1:0] ibus_address,
  input  logic            ibus_waitrequest,
  input  logic [XLEN-1:0] ibus_readdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  ifu_state_t      r_state;
  ifu_state_t      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_hold;
  logic            w_hold_ld;
  logic [XLEN-1:0] w_target_raw;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;
  logic            w_branch_sel_unused;

  // branch_take only documents the source; the trap target wins whenever both are set.
  assign w_branch_sel_unused = branch_take;
  assign w_target_raw        = trap_take ? trap_pc : branch_pc;
  assign w_target            = w_target_raw & ~XLEN'(3);
  assign w_pc_inc            = r_pc + XLEN'(4);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_ld   = 1'b0;
    ibus_read   = 1'b0;
    if_valid    = 1'b0;
    case (r_state)
      S_RESET: begin
        w_state_nxt = S_REQ;
        if (if_flush) w_pc_nxt = w_target;
      end
      S_REQ: begin
        ibus_read = ~if_flush;
        if (if_flush) begin
          w_pc_nxt = w_target;
        end else if (!ibus_waitrequest) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (if_flush) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else begin
          if_valid = 1'b1;
          if (if_stall) begin
            w_hold_ld   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if (if_flush) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (!if_stall) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
    // A reset cycle drops any in-flight response and issues nothing new.
    if (rst) begin
      ibus_read = 1'b0;
      if_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
      r_pc    <= PC_RESET;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hold_ld) r_hold <= ibus_readdata;
    end
  end

  assign ibus_address = r_pc;
  assign if_pc        = r_pc;
  assign if_instr     = (r_state == S_RESP) ? ibus_readdata : r_hold;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios with literal expectations, then randomized
// traffic, all checked cycle by cycle against a fetch-level reference model.
module tb_ifu;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_stall = 1'b0;
  logic        if_flush = 1'b0;
  logic        branch_take = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        trap_take = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        ibus_read;
  logic [31:0] ibus_address;
  logic        ibus_waitrequest = 1'b0;
  logic [31:0] ibus_readdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  ifu #(.XLEN(32), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .if_stall(if_stall), .if_flush(if_flush),
    .branch_take(branch_take), .branch_pc(branch_pc),
    .trap_take(trap_take), .trap_pc(trap_pc),
    .ibus_read(ibus_read), .ibus_address(ibus_address),
    .ibus_waitrequest(ibus_waitrequest), .ibus_readdata(ibus_readdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: where the next fetch goes, whether a word is arriving,
  // whether a word is parked for a stalled decode, and whether we just left reset.
  bit          m_known = 0;
  bit          m_boot = 0, m_resp = 0, m_held = 0;
  logic [31:0] m_pc = '0, m_hold_val = '0;

  // Bus slave: remembers the last accepted address and answers one cycle later.
  bit          slv_pend = 0;
  logic [31:0] slv_addr = '0;
  logic [31:0] drv_data = '0;

  logic        obs_read, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit f, input bit bt,
                     input logic [31:0] bp, input bit tt, input logic [31:0] tp,
                     input bit w);
    bit          exp_read, exp_valid;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; if_stall = s; if_flush = f; branch_take = bt; branch_pc = bp;
    trap_take = tt; trap_pc = tp; ibus_waitrequest = w;
    drv_data = slv_pend ? (slv_addr ^ KEY) : $urandom;
    ibus_readdata = drv_data;
    #1;
    obs_read = ibus_read; obs_valid = if_valid; obs_addr = ibus_address;
    obs_instr = if_instr; obs_pc = if_pc;
    if (m_known) begin
      exp_read  = !r && !m_boot && !m_resp && !m_held && !f;
      exp_valid = !r && ((m_resp && !f) || m_held);
      chk("m_read", {31'b0, obs_read}, {31'b0, exp_read});
      chk("m_valid", {31'b0, obs_valid}, {31'b0, exp_valid});
      chk("m_pc", obs_pc, m_pc);
      if (exp_read) chk("m_addr", obs_addr, m_pc);
      if (exp_valid) chk("m_instr", obs_instr, m_resp ? drv_data : m_hold_val);
    end
    @(posedge clk);
    slv_pend = obs_read && !w;
    slv_addr = obs_addr;
    tgt = (tt ? tp : bp) & 32'hFFFF_FFFC;
    if (r) begin
      m_known = 1; m_boot = 1; m_resp = 0; m_held = 0; m_pc = 32'h0; m_hold_val = '0;
    end else if (!m_known) begin
      m_boot = 0;
    end else if (f) begin
      m_pc = tgt; m_boot = 0; m_resp = 0; m_held = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_resp) begin
      m_resp = 0;
      if (s) begin m_held = 1; m_hold_val = drv_data; end
      else m_pc = m_pc + 32'd4;
    end else if (m_held) begin
      if (!s) begin m_held = 0; m_pc = m_pc + 32'd4; end
    end else begin
      m_resp = !w;
    end
  endtask

  task automatic step(input bit s, input bit w);
    cyc(0, s, 0, 0, 32'h0, 0, 32'h0, w);
  endtask

  initial begin
    // Reset and zero-wait straight-line fetch.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0);
    chk("t1_rst_read", {31'b0, obs_read}, 32'd0);
    chk("t1_rst_valid", {31'b0, obs_valid}, 32'd0);
    chk("t1_rst_pc", obs_pc, 32'h0);
    chk("t1_rst_instr", obs_instr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("t1_req", {31'b0, obs_read}, 32'd1);
      chk("t1_addr", obs_addr, 32'(i * 4));
      step(0, 0);
      chk("t1_valid", {31'b0, obs_valid}, 32'd1);
      chk("t1_pc", obs_pc, 32'(i * 4));
      chk("t1_instr", obs_instr, 32'(i * 4) ^ 32'hA5A5_0000);
    end
    // Wait states on 0x10.
    step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, (i < 3));
      chk("t2_read", {31'b0, obs_read}, 32'd1);
      chk("t2_addr", obs_addr, 32'h10);
    end
    step(0, 0);
    chk("t2_valid", {31'b0, obs_valid}, 32'd1);
    chk("t2_instr", obs_instr, 32'hA5A5_0010);
    chk("t2_noreq", {31'b0, obs_read}, 32'd0);
    // Stall hold on 0x20.
    for (int i = 0; i < 3; i++) begin step(0, 0); step(0, 0); end
    step(0, 0);
    chk("t3_addr", obs_addr, 32'h20);
    for (int i = 0; i < 5; i++) begin
      step((i < 4), 0);
      chk("t3_valid", {31'b0, obs_valid}, 32'd1);
      chk("t3_pc", obs_pc, 32'h20);
      chk("t3_instr", obs_instr, 32'hA5A5_0020);
      chk("t3_noreq", {31'b0, obs_read}, 32'd0);
    end
    step(0, 0);
    chk("t3_next", obs_addr, 32'h24);
    chk("t3_next_rd", {31'b0, obs_read}, 32'd1);
    // Flush in response, then flush+stall with trap winning.
    cyc(0, 0, 1, 1, 32'h100, 0, 32'h0, 0);
    chk("t4_drop", {31'b0, obs_valid}, 32'd0);
    step(0, 0);
    chk("t4_br_addr", obs_addr, 32'h100);
    cyc(0, 1, 1, 1, 32'h100, 1, 32'h200, 0);
    chk("t4_drop2", {31'b0, obs_valid}, 32'd0);
    step(0, 0);
    chk("t4_trap_addr", obs_addr, 32'h200);
    // Reset mid-response, alignment, wrap.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_rst_valid", {31'b0, obs_valid}, 32'd0);
    step(0, 0);
    chk("t5_boot_read", {31'b0, obs_read}, 32'd0);
    step(0, 1);
    chk("t5_req_rd", {31'b0, obs_read}, 32'd1);
    chk("t5_req_addr", obs_addr, 32'h0);
    cyc(0, 0, 1, 1, 32'h203, 0, 32'h0, 1);
    chk("t5_flush_rd", {31'b0, obs_read}, 32'd0);
    step(0, 1);
    chk("t5_align", obs_addr, 32'h200);
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    step(0, 0);
    chk("t5_top_addr", obs_addr, 32'hFFFF_FFFC);
    step(0, 0);
    chk("t5_top_instr", obs_instr, 32'h5A5A_FFFC);
    step(0, 0);
    chk("t5_wrap", obs_addr, 32'h0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bp, tp;
      bp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      tp = $urandom;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, bp,
          $urandom_range(0, 1) == 1, tp, ($urandom_range(0, 2) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the veriRISCV IF stage. It holds the program counter, drives the instruction bus (Avalon-style read master with fixed read latency of 1), and presents fetched instructions to the IF/ID pipeline register. It consumes the HDU outputs `if_stall` and `if_flush`, plus the redirect targets from EX (branch) and WB (trap).

## Interface

Parameters:
- `XLEN`, default 32: address and data width.
- `PC_RESET`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `if_stall`  in  1  from HDU; hold the current instruction and PC.
- `if_flush`  in  1  from HDU; discard the current fetch and redirect.
- `branch_take`  in  1  branch taken in EX; selects the redirect source.
- `branch_pc`  in  XLEN  branch target.
- `trap_take`  in  1  trap taken in WB; selects the redirect source.
- `trap_pc`  in  XLEN  trap or mret target.
- `ibus_read`  out  1  read request.
- `ibus_address`  out  XLEN  read address; equals the current PC.
- `ibus_waitrequest`  in  1  slave stalls the request.
- `ibus_readdata`  in  XLEN  valid exactly 1 cycle after an accepted read.
- `if_valid`  out  1  `if_instr` and `if_pc` are valid this cycle.
- `if_instr`  out  XLEN  fetched instruction.
- `if_pc`  out  XLEN  PC of `if_instr`.

## Operation

- **Accept:** a read is accepted when `ibus_read & ~ibus_waitrequest`.
- **Redirect target:**
  - `trap_pc` when `trap_take`, else `branch_pc`.
  - Bits [1:0] are forced to 0.
  - Redirect happens only when `if_flush=1`. `branch_take` and `trap_take` only select the source.
- **Flush precedence:** `if_flush` has priority over `if_stall` in every state.
- **States:**
  - `S_RESET`:
    - Entered on `rst`. `ibus_read=0`, `if_valid=0`.
    - Next cycle goes to `S_REQ`. A flush here loads the target into the PC.
  - `S_REQ`:
    - `ibus_read = ~if_flush`, `ibus_address = pc`.
    - On flush: pc <= target, stay in `S_REQ`.
    - On accept: go to `S_RESP`.
    - Otherwise stay. `if_stall` does not block issuing.
    - Deasserting `ibus_read` during a flush is permitted even while `ibus_waitrequest=1`; the bus slave shall tolerate it.
  - `S_RESP` (read data present on `ibus_readdata`):
    - Flush: data dropped, pc <= target, go to `S_REQ`, `if_valid=0`.
    - No stall: `if_valid=1`, `if_instr = ibus_readdata`, pc <= pc+4, go to `S_REQ`.
    - Stall: `if_valid=1`, `if_instr = ibus_readdata`, hold register <= `ibus_readdata`, go to `S_HOLD`.
  - `S_HOLD`:
    - `if_valid=1`, `if_instr` = hold register, `ibus_read=0`.
    - Flush: pc <= target, go to `S_REQ`.
    - `~if_stall`: pc <= pc+4, go to `S_REQ`.
    - Otherwise stay.
- **`if_instr` mux:** `ibus_readdata` in `S_RESP`, else the hold register.
- **`if_pc`:** always the pc register.
- **Arithmetic:** pc+4 is XLEN-bit and wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).

## Timing

- **Reset values:**
  - state `S_RESET`, pc = `PC_RESET`, hold register = 0.
  - Hence `ibus_read=0`, `if_valid=0`, `if_pc=PC_RESET`, `if_instr=0`.
- **Reset mid-operation:** reset in any state, including `S_RESP`, drops any in-flight response. The first request is issued 2 cycles after `rst` falls: the cycle in `S_RESET`, then `S_REQ`.
- **Latency:**
  - Zero-wait bus: request in cycle N, instruction valid in N+1, next request in N+2.
  - Peak throughput is 1 instruction per 2 cycles.
  - Each bus wait cycle adds 1.
- **Combinational paths:**
  - `if_flush` -> `ibus_read`.
  - `ibus_readdata` -> `if_instr` in `S_RESP`.
  - No combinational path from `ibus_waitrequest` to any output.
- **Redirect latency:** a flush in cycle N makes cycle N+1 issue at the target.
- **Simultaneous events:**
  - Flush with stall: treated as flush.
  - `trap_take` with `branch_take`: trap target wins.

## Structure

- Shared package `core_pkg` (or `core.svh`) holds:
  - `ifu_state_t` enum: `S_RESET`, `S_REQ`, `S_RESP`, `S_HOLD`.
  - `XLEN` default.
  - `PC_RESET` default.
- Single module; no sub-module. The redirect mux and pc+4 adder are inline.
- Estimated size 120–180 lines.

## Test plan

1. **Reset, zero-wait straight line:** reset with `PC_RESET=0`, zero-wait slave returning `addr ^ 32'hA5A5_0000` -> requests at 0, 4, 8 on every other cycle; `if_valid` pulses with `if_pc`=0/4/8 and matching data.
2. **Wait states:** `ibus_waitrequest=1` for 3 cycles on address 0x10 -> `ibus_read` and `ibus_address` held for 4 cycles; `if_valid` 1 cycle after the accepted cycle; no duplicate request.
3. **Stall hold:** `if_stall=1` for 4 cycles starting in `S_RESP` of 0x20 -> `if_valid=1`, `if_pc=0x20`, `if_instr` constant for 5 cycles; next request is 0x24 the cycle after the stall drops.
4. **Flush with stall, trap priority:**
   - `branch_take=1`, `branch_pc=0x100` with `if_flush=1` during `S_RESP` -> that data dropped (`if_valid=0`), next request at 0x100.
   - Repeat with `if_stall=1` and `trap_take=1`, `trap_pc=0x200` -> request at 0x200.
5. **Reset mid-fetch, alignment, wrap:**
   - Assert `rst` during `S_RESP` -> no `if_valid`; next request at `PC_RESET` 2 cycles after reset release.
   - Redirect to 0x203 -> address 0x200.
   - pc 0xFFFF_FFFC -> next fetch address 0x0.
